// File: rtl/io_bus_router.sv
// io_bus_router: one MMIO master to NUM_SLAVES IO cores via IDLE/WAIT/RESP handshake.
// Optional WAIT timeout enabled by defining IO_BUS_TIMEOUT_EN.
module io_bus_router #(
  parameter int                            NUM_SLAVES     = 4,
  parameter int                            REGION_SHIFT   = 8,
  parameter logic [NUM_SLAVES-1:0][31:0]   BASE_ADDRS     = '0,
  parameter int                            TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       io_bus_m_rd_en,
  input  logic                       io_bus_m_wr_en,
  input  logic [31:0]                io_bus_m_address,
  input  logic [31:0]                io_bus_m_wr_data,
  output logic                       io_bus_m_ready,
  output logic                       io_bus_m_resp_valid,
  output logic                       io_bus_m_resp_err,
  output logic [31:0]                io_bus_m_rd_data,
  output logic [NUM_SLAVES-1:0]      io_bus_s_rd_en,
  output logic [NUM_SLAVES-1:0]      io_bus_s_wr_en,
  output logic [31:0]                io_bus_s_address,
  output logic [31:0]                io_bus_s_wr_data,
  input  logic [32*NUM_SLAVES-1:0]   io_bus_s_rd_data,
  input  logic [NUM_SLAVES-1:0]      io_bus_s_ready
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
  begin : g_param_check
    $error("io_bus_router: NUM_SLAVES or TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic             is_write, is_write_next;
  logic             err_q, err_next;
  logic [31:0]      address_next, wr_data_next, rd_data_next;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             sel_ready;
  logic [31:0]      sel_data;

`ifdef IO_BUS_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt, cnt_next;
`endif

  // Downward scan so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((io_bus_m_address >> REGION_SHIFT) == (BASE_ADDRS[i] >> REGION_SHIFT)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    sel_ready      = 1'b0;
    sel_data       = '0;
    io_bus_s_rd_en = '0;
    io_bus_s_wr_en = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_ready = io_bus_s_ready[i];
        sel_data  = io_bus_s_rd_data[32*i +: 32];
        if (state == WAIT) begin
          io_bus_s_rd_en[i] = ~is_write;
          io_bus_s_wr_en[i] = is_write;
        end
      end
    end
  end

  assign io_bus_m_ready      = (state == IDLE);
  assign io_bus_m_resp_valid = (state == RESP);
  assign io_bus_m_resp_err   = (state == RESP) & err_q;

  always_comb begin
    state_next    = state;
    idx_next      = idx;
    is_write_next = is_write;
    err_next      = err_q;
    address_next  = io_bus_s_address;
    wr_data_next  = io_bus_s_wr_data;
    rd_data_next  = io_bus_m_rd_data;
`ifdef IO_BUS_TIMEOUT_EN
    cnt_next      = cnt;
`endif
    case (state)
      IDLE: begin
        if (io_bus_m_rd_en && io_bus_m_wr_en) begin
          state_next   = RESP;
          err_next     = 1'b1;
          rd_data_next = '0;
        end else if (io_bus_m_rd_en || io_bus_m_wr_en) begin
          address_next  = io_bus_m_address;
          wr_data_next  = io_bus_m_wr_data;
          is_write_next = io_bus_m_wr_en;
          idx_next      = hit_idx;
          if (hit) begin
            state_next = WAIT;
`ifdef IO_BUS_TIMEOUT_EN
            cnt_next   = '0;
`endif
          end else begin
            state_next   = RESP;
            err_next     = 1'b1;
            rd_data_next = '0;
          end
        end
      end
      WAIT: begin
        // Ready takes priority over a timeout landing on the same cycle.
        if (sel_ready) begin
          state_next   = RESP;
          err_next     = 1'b0;
          rd_data_next = is_write ? 32'h0 : sel_data;
        end
`ifdef IO_BUS_TIMEOUT_EN
        else if (cnt == TIMEOUT_LIMIT) begin
          state_next   = RESP;
          err_next     = 1'b1;
          rd_data_next = '0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
`endif
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      idx              <= '0;
      is_write         <= 1'b0;
      err_q            <= 1'b0;
      io_bus_s_address <= '0;
      io_bus_s_wr_data <= '0;
      io_bus_m_rd_data <= '0;
`ifdef IO_BUS_TIMEOUT_EN
      cnt              <= '0;
`endif
    end else begin
      state            <= state_next;
      idx              <= idx_next;
      is_write         <= is_write_next;
      err_q            <= err_next;
      io_bus_s_address <= address_next;
      io_bus_s_wr_data <= wr_data_next;
      io_bus_m_rd_data <= rd_data_next;
`ifdef IO_BUS_TIMEOUT_EN
      cnt              <= cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_io_bus_router.sv
// tb_io_bus_router: directed checks of io_bus_router (4 slaves at 0x100/0x200/0x300/0x400).
// Timeout scenario follows IO_BUS_TIMEOUT_EN with TIMEOUT_CYCLES=8.
module tb_io_bus_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_bus_m_rd_en, io_bus_m_wr_en;
  logic [31:0] io_bus_m_address, io_bus_m_wr_data;
  logic        io_bus_m_ready, io_bus_m_resp_valid, io_bus_m_resp_err;
  logic [31:0] io_bus_m_rd_data;
  logic [3:0]  io_bus_s_rd_en, io_bus_s_wr_en;
  logic [31:0] io_bus_s_address, io_bus_s_wr_data;
  logic [127:0] io_bus_s_rd_data;
  logic [3:0]  io_bus_s_ready;

  int total = 0;
  int bad   = 0;

  io_bus_router #(
    .NUM_SLAVES    (4),
    .REGION_SHIFT  (8),
    .BASE_ADDRS    ({32'h0000_0400, 32'h0000_0300, 32'h0000_0200, 32'h0000_0100}),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .io_bus_m_rd_en     (io_bus_m_rd_en),
    .io_bus_m_wr_en     (io_bus_m_wr_en),
    .io_bus_m_address   (io_bus_m_address),
    .io_bus_m_wr_data   (io_bus_m_wr_data),
    .io_bus_m_ready     (io_bus_m_ready),
    .io_bus_m_resp_valid(io_bus_m_resp_valid),
    .io_bus_m_resp_err  (io_bus_m_resp_err),
    .io_bus_m_rd_data   (io_bus_m_rd_data),
    .io_bus_s_rd_en     (io_bus_s_rd_en),
    .io_bus_s_wr_en     (io_bus_s_wr_en),
    .io_bus_s_address   (io_bus_s_address),
    .io_bus_s_wr_data   (io_bus_s_wr_data),
    .io_bus_s_rd_data   (io_bus_s_rd_data),
    .io_bus_s_ready     (io_bus_s_ready)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    io_bus_m_rd_en = 1'b0; io_bus_m_wr_en = 1'b0;
    io_bus_m_address = '0; io_bus_m_wr_data = '0;
    io_bus_s_ready = '0;
    step(); step();
    rst = 1'b0;
    total++; if (io_bus_m_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", io_bus_m_ready); end
    total++; if (io_bus_m_resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", io_bus_m_resp_valid); end
    total++; if ({io_bus_s_rd_en, io_bus_s_wr_en} !== 8'h00) begin bad++; $display("[TB] FAIL reset_en got=%h want=00", {io_bus_s_rd_en, io_bus_s_wr_en}); end
    total++; if (io_bus_s_address !== 32'h0) begin bad++; $display("[TB] FAIL reset_addr got=%h want=0", io_bus_s_address); end
    total++; if (io_bus_m_rd_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata got=%h want=0", io_bus_m_rd_data); end
  endtask

  task automatic test_read_hit();
    io_bus_s_ready = 4'hF;
    io_bus_m_rd_en = 1'b1; io_bus_m_address = 32'h0000_0204;
    step();
    io_bus_m_rd_en = 1'b0;
    total++; if (io_bus_s_rd_en !== 4'b0010) begin bad++; $display("[TB] FAIL hit_rd_en got=%b want=0010", io_bus_s_rd_en); end
    total++; if (io_bus_m_ready !== 1'b0) begin bad++; $display("[TB] FAIL hit_ready got=%b want=0", io_bus_m_ready); end
    total++; if (io_bus_s_address !== 32'h0000_0204) begin bad++; $display("[TB] FAIL hit_addr got=%h want=00000204", io_bus_s_address); end
    step();
    total++; if (io_bus_m_resp_valid !== 1'b1) begin bad++; $display("[TB] FAIL hit_valid got=%b want=1", io_bus_m_resp_valid); end
    total++; if (io_bus_m_rd_data !== 32'hCAFE_0001) begin bad++; $display("[TB] FAIL hit_rdata got=%h want=cafe0001", io_bus_m_rd_data); end
    total++; if (io_bus_m_resp_err !== 1'b0) begin bad++; $display("[TB] FAIL hit_err got=%b want=0", io_bus_m_resp_err); end
    total++; if (io_bus_s_rd_en !== 4'b0000) begin bad++; $display("[TB] FAIL hit_en_drop got=%b want=0000", io_bus_s_rd_en); end
    step();
    total++; if (io_bus_m_ready !== 1'b1) begin bad++; $display("[TB] FAIL hit_ready_back got=%b want=1", io_bus_m_ready); end
  endtask

  task automatic test_decode_miss();
    io_bus_s_ready = 4'hF;
    io_bus_m_rd_en = 1'b1; io_bus_m_address = 32'hFFFF_0000;
    step();
    io_bus_m_rd_en = 1'b0;
    total++; if (io_bus_s_rd_en !== 4'b0000) begin bad++; $display("[TB] FAIL miss_rd_en got=%b want=0000", io_bus_s_rd_en); end
    total++; if (io_bus_m_resp_valid !== 1'b1) begin bad++; $display("[TB] FAIL miss_valid got=%b want=1", io_bus_m_resp_valid); end
    total++; if (io_bus_m_resp_err !== 1'b1) begin bad++; $display("[TB] FAIL miss_err got=%b want=1", io_bus_m_resp_err); end
    total++; if (io_bus_m_rd_data !== 32'h0) begin bad++; $display("[TB] FAIL miss_rdata got=%h want=0", io_bus_m_rd_data); end
    step();
    total++; if (io_bus_m_ready !== 1'b1) begin bad++; $display("[TB] FAIL miss_ready_back got=%b want=1", io_bus_m_ready); end
  endtask

  task automatic test_write_wait();
    io_bus_s_ready = 4'b1011;
    io_bus_m_wr_en = 1'b1; io_bus_m_address = 32'h0000_0300; io_bus_m_wr_data = 32'h0000_00AA;
    step();
    io_bus_m_wr_en = 1'b0; io_bus_m_wr_data = 32'h0;
    for (int k = 0; k < 6; k++) begin
      total++; if (io_bus_s_wr_en !== 4'b0100) begin bad++; $display("[TB] FAIL wr_en_c%0d got=%b want=0100", k, io_bus_s_wr_en); end
      total++; if ({io_bus_m_ready, io_bus_m_resp_valid} !== 2'b00) begin bad++; $display("[TB] FAIL wr_busy_c%0d got=%b want=00", k, {io_bus_m_ready, io_bus_m_resp_valid}); end
      total++; if (io_bus_s_wr_data !== 32'h0000_00AA) begin bad++; $display("[TB] FAIL wr_data_c%0d got=%h want=000000aa", k, io_bus_s_wr_data); end
      if (k == 5) io_bus_s_ready = 4'b0100;
      step();
    end
    io_bus_s_ready = 4'b0000;
    total++; if (io_bus_m_resp_valid !== 1'b1) begin bad++; $display("[TB] FAIL wr_valid got=%b want=1", io_bus_m_resp_valid); end
    total++; if (io_bus_m_resp_err !== 1'b0) begin bad++; $display("[TB] FAIL wr_err got=%b want=0", io_bus_m_resp_err); end
    total++; if (io_bus_s_wr_en !== 4'b0000) begin bad++; $display("[TB] FAIL wr_en_drop got=%b want=0000", io_bus_s_wr_en); end
    total++; if (io_bus_m_ready !== 1'b0) begin bad++; $display("[TB] FAIL wr_ready_resp got=%b want=0", io_bus_m_ready); end
    step();
    total++; if (io_bus_m_resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL wr_single_pulse got=%b want=0", io_bus_m_resp_valid); end
    total++; if (io_bus_m_ready !== 1'b1) begin bad++; $display("[TB] FAIL wr_ready_back got=%b want=1", io_bus_m_ready); end
    total++; if (io_bus_s_wr_data !== 32'h0000_00AA) begin bad++; $display("[TB] FAIL wr_data_hold got=%h want=000000aa", io_bus_s_wr_data); end
  endtask

  task automatic test_illegal();
    io_bus_s_ready = 4'hF;
    io_bus_m_rd_en = 1'b1; io_bus_m_wr_en = 1'b1; io_bus_m_address = 32'h0000_0104;
    step();
    io_bus_m_wr_en = 1'b0; io_bus_m_address = 32'h0000_0404;
    total++; if ({io_bus_s_rd_en, io_bus_s_wr_en} !== 8'h00) begin bad++; $display("[TB] FAIL ill_en got=%h want=00", {io_bus_s_rd_en, io_bus_s_wr_en}); end
    total++; if ({io_bus_m_resp_valid, io_bus_m_resp_err} !== 2'b11) begin bad++; $display("[TB] FAIL ill_resp got=%b want=11", {io_bus_m_resp_valid, io_bus_m_resp_err}); end
    step();
    total++; if ({io_bus_m_ready, io_bus_s_rd_en} !== 5'b1_0000) begin bad++; $display("[TB] FAIL ill_idle got=%b want=10000", {io_bus_m_ready, io_bus_s_rd_en}); end
    step();
    io_bus_m_rd_en = 1'b0;
    total++; if (io_bus_s_rd_en !== 4'b1000) begin bad++; $display("[TB] FAIL ill_next_rd_en got=%b want=1000", io_bus_s_rd_en); end
    step();
    total++; if (io_bus_m_rd_data !== 32'hCAFE_0003) begin bad++; $display("[TB] FAIL ill_next_rdata got=%h want=cafe0003", io_bus_m_rd_data); end
    total++; if ({io_bus_m_resp_valid, io_bus_m_resp_err} !== 2'b10) begin bad++; $display("[TB] FAIL ill_next_resp got=%b want=10", {io_bus_m_resp_valid, io_bus_m_resp_err}); end
    step();
  endtask

  task automatic test_timeout();
    io_bus_s_ready = 4'b1110;
    io_bus_m_rd_en = 1'b1; io_bus_m_address = 32'h0000_0100;
    step();
    io_bus_m_rd_en = 1'b0;
`ifdef IO_BUS_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      total++; if ({io_bus_s_rd_en, io_bus_m_resp_valid} !== 5'b0001_0) begin bad++; $display("[TB] FAIL to_wait_c%0d got=%b want=00010", k, {io_bus_s_rd_en, io_bus_m_resp_valid}); end
      step();
    end
    total++; if (io_bus_s_rd_en !== 4'b0000) begin bad++; $display("[TB] FAIL to_en_drop got=%b want=0000", io_bus_s_rd_en); end
    total++; if ({io_bus_m_resp_valid, io_bus_m_resp_err} !== 2'b11) begin bad++; $display("[TB] FAIL to_resp got=%b want=11", {io_bus_m_resp_valid, io_bus_m_resp_err}); end
    total++; if (io_bus_m_rd_data !== 32'h0) begin bad++; $display("[TB] FAIL to_rdata got=%h want=0", io_bus_m_rd_data); end
    step();
`else
    begin
      int seen_valid = 0;
      for (int k = 0; k < 1000; k++) begin
        if (io_bus_m_resp_valid === 1'b1) seen_valid++;
        step();
      end
      total++; if (seen_valid != 0) begin bad++; $display("[TB] FAIL nto_no_resp got=%0d want=0", seen_valid); end
    end
    total++; if ({io_bus_s_rd_en, io_bus_m_ready} !== 5'b0001_0) begin bad++; $display("[TB] FAIL nto_still_wait got=%b want=00010", {io_bus_s_rd_en, io_bus_m_ready}); end
    io_bus_s_ready = 4'b0001;
    step();
    total++; if ({io_bus_m_resp_valid, io_bus_m_resp_err} !== 2'b10) begin bad++; $display("[TB] FAIL nto_resp got=%b want=10", {io_bus_m_resp_valid, io_bus_m_resp_err}); end
    total++; if (io_bus_m_rd_data !== 32'hCAFE_0000) begin bad++; $display("[TB] FAIL nto_rdata got=%h want=cafe0000", io_bus_m_rd_data); end
    step();
`endif
  endtask

  task automatic test_reset_mid();
    io_bus_s_ready = 4'b0000;
    io_bus_m_wr_en = 1'b1; io_bus_m_address = 32'h0000_0200; io_bus_m_wr_data = 32'h0000_0055;
    step();
    io_bus_m_wr_en = 1'b0;
    total++; if (io_bus_s_wr_en !== 4'b0010) begin bad++; $display("[TB] FAIL rm_wr_en got=%b want=0010", io_bus_s_wr_en); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if ({io_bus_s_rd_en, io_bus_s_wr_en} !== 8'h00) begin bad++; $display("[TB] FAIL rm_en got=%h want=00", {io_bus_s_rd_en, io_bus_s_wr_en}); end
    total++; if ({io_bus_m_ready, io_bus_m_resp_valid} !== 2'b10) begin bad++; $display("[TB] FAIL rm_status got=%b want=10", {io_bus_m_ready, io_bus_m_resp_valid}); end
    total++; if (io_bus_s_address !== 32'h0) begin bad++; $display("[TB] FAIL rm_addr got=%h want=0", io_bus_s_address); end
    step();
    total++; if (io_bus_m_resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rm_no_resp got=%b want=0", io_bus_m_resp_valid); end
    io_bus_s_ready = 4'hF;
    io_bus_m_rd_en = 1'b1; io_bus_m_address = 32'h0000_0304;
    step();
    io_bus_m_rd_en = 1'b0;
    total++; if (io_bus_s_rd_en !== 4'b0100) begin bad++; $display("[TB] FAIL rm_new_rd_en got=%b want=0100", io_bus_s_rd_en); end
    step();
    total++; if ({io_bus_m_resp_valid, io_bus_m_resp_err} !== 2'b10) begin bad++; $display("[TB] FAIL rm_new_resp got=%b want=10", {io_bus_m_resp_valid, io_bus_m_resp_err}); end
    total++; if (io_bus_m_rd_data !== 32'hCAFE_0002) begin bad++; $display("[TB] FAIL rm_new_rdata got=%h want=cafe0002", io_bus_m_rd_data); end
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    io_bus_s_rd_data = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    test_reset();
    test_read_hit();
    test_decode_miss();
    test_write_wait();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_bus_router.md
Name: io_bus_router

Overview:
- Parametrised successor to the fixed two-slave IO interconnect.
- Routes one core-side MMIO master to NUM_SLAVES IO cores through a decoded, registered request/response handshake.
- Adds per-slave one-hot enables, slave wait-states (ready), decode-miss and illegal-command error responses, and an optional timeout.
- Sits between the core's IO bus port and the timer, UART and future IO cores.

Parameters:
- NUM_SLAVES, 4: number of IO cores; range 1..16.
- REGION_SHIFT, 8: low address bits ignored by decode; compare is address[31:REGION_SHIFT].
- BASE_ADDRS, {32'h0, ...}: packed array [NUM_SLAVES-1:0][31:0]; slave i owns base[31:REGION_SHIFT].
- TIMEOUT_CYCLES, 255: WAIT cycles before forced error; 1..65535.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- io_bus_m_rd_en  in  1  master read request.
- io_bus_m_wr_en  in  1  master write request.
- io_bus_m_address  in  32  request address.
- io_bus_m_wr_data  in  32  write data.
- io_bus_m_ready  out  1  router idle; request accepted on any cycle where this and an enable are high.
- io_bus_m_resp_valid  out  1  one-cycle response pulse.
- io_bus_m_resp_err  out  1  response is an error; valid with resp_valid.
- io_bus_m_rd_data  out  32  read data; valid with resp_valid.
- io_bus_s_rd_en  out  NUM_SLAVES  one-hot read enable.
- io_bus_s_wr_en  out  NUM_SLAVES  one-hot write enable.
- io_bus_s_address  out  32  latched request address, shared by all slaves.
- io_bus_s_wr_data  out  32  latched write data, shared by all slaves.
- io_bus_s_rd_data  in  32*NUM_SLAVES  flattened slave read data; slave i is at [32*i+:32].
- io_bus_s_ready  in  NUM_SLAVES  slave completes its access this cycle.

Behaviour:
- Reset (sync, active-high, clk edge):
  - state=IDLE, m_ready=1, resp_valid=0, resp_err=0, m_rd_data=0.
  - All s_rd_en/s_wr_en=0; s_address=0, s_wr_data=0; timeout counter=0.
  - Reset mid-transaction aborts silently: no response is issued, and enables drop on the reset edge.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - m_ready=1.
  - On cycle T with rd_en^wr_en: latch address, wr_data, command and decoded index; m_ready=0 from T+1.
  - Decode: compare against every BASE_ADDRS entry; lowest matching index wins.
  - Hit: at T+1 assert bit idx of s_rd_en or s_wr_en; go to WAIT.
  - Miss: no slave enable; go to RESP with err=1, rd_data=0.
  - rd_en and wr_en both high: illegal command; no slave access; RESP with err=1.
  - Neither high: stay in IDLE.
- WAIT:
  - Enable stays high until s_ready[idx]=1.
  - On that cycle, capture s_rd_data[idx] (reads) or 0 (writes); drop the enable on the next edge; go to RESP with err=0.
  - s_ready bits of non-selected slaves are ignored.
  - Ready in the first WAIT cycle is legal: request-to-response latency is 2 cycles.
- RESP:
  - resp_valid=1 for exactly one cycle with rd_data and err.
  - Next state IDLE; m_ready=1 on the following cycle.
  - Minimum back-to-back spacing is 3 cycles per transaction for zero-wait slaves.
- Master behaviour: master enables are ignored while m_ready=0; the master must hold or re-issue the request.
- s_address and s_wr_data hold their last latched value between transactions.

Optional Feature:
- Macro IO_BUS_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on WAIT entry and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without s_ready[idx]: drop the enable, go to RESP with err=1, rd_data=0.
  - If s_ready[idx] arrives on the timeout cycle, ready wins and err=0.
- Undefined: no counter; WAIT persists indefinitely until ready.

Test Plan:
- Reset, then read slave 1 (BASE_ADDRS[1]=32'h0000_0200, addr 32'h0000_0204) with s_ready tied high and s_rd_data[1]=32'hCAFE_0001:
  - s_rd_en=4'b0010 for one cycle at T+1.
  - resp_valid at T+2 with rd_data=32'hCAFE_0001, err=0.
- Write 32'h0000_00AA to slave 2 with ready delayed 5 cycles:
  - s_wr_en=4'b0100 held for 6 cycles with s_wr_data=32'hAA.
  - Single resp_valid with err=0; m_ready low throughout.
- Read unmapped address 32'hFFFF_0000:
  - No s_rd_en bit set; resp_valid at T+1 with err=1, rd_data=0.
- rd_en=wr_en=1 simultaneously to a mapped address:
  - No slave enable; err=1 response.
  - A following legal read is accepted 2 cycles later.
- With IO_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave 0 never ready:
  - Enable drops after 8 WAIT cycles; resp err=1.
  - Without the macro, still waiting after 1000 cycles.
- Assert rst during WAIT:
  - Next cycle all enables=0, no resp_valid, m_ready=1.
  - A new request completes normally.
